shift_ser_tx: RTL



---
 rtl/shift_ser_tx.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/shift_ser_tx.sv
// -----------------------------------------------------------------------------
// shift_ser_tx
//
// Parallel-to-serial transmit stage. A w-bit word is captured over a
// valid/ready handshake and shifted out one bit per accepted beat on a 1-bit
// valid/ready stream. The internal shift is a logical shift with zero fill.
// The next word can only be captured after the FSM has returned to IDLE.
//
// Parameters:
//   w          word width in bits (w >= 2)
//   lsb_first  1: bit 0 goes first (right shift); 0: bit w-1 goes first
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active-high
//   d        in   parallel word to transmit
//   d_valid  in   d holds a valid word
//   d_ready  out  word can be captured (state == IDLE)
//   s_out    out  current serial bit
//   s_valid  out  s_out is valid
//   s_ready  in   consumer accepts s_out this cycle
//   s_last   out  current beat is the final beat of the word
//   busy     out  state != IDLE
//   done     out  one-cycle pulse after the final beat is accepted
//
// Optional feature (compile-time macro SHIFT_SER_TX_PARITY_EN):
//   appends an even-parity beat (XOR of all bits of d) after the data beats.
//   s_last then marks only the parity beat.
// -----------------------------------------------------------------------------
module shift_ser_tx #(
    parameter int w         = 4,
    parameter bit lsb_first = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [w-1:0] d,
    input  logic         d_valid,
    output logic         d_ready,
    output logic         s_out,
    output logic         s_valid,
    input  logic         s_ready,
    output logic         s_last,
    output logic         busy,
    output logic         done
);

    // Beat counter must hold 0..w.
    localparam int CW = $clog2(w + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(w - 1);
`ifndef SHIFT_SER_TX_PARITY_EN
    // The beat after this one is the final data beat.
    localparam logic [CW-1:0] CNT_PENULT = CW'(w - 2);
`endif

`ifdef SHIFT_SER_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t         state_q, state_d;
    logic [w-1:0]   sr_q, sr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           s_out_q, s_out_d;
    logic           s_valid_q, s_valid_d;
    logic           s_last_q, s_last_d;
    logic           done_q, done_d;
    logic [w-1:0]   sr_shift;
`ifdef SHIFT_SER_TX_PARITY_EN
    logic           parity_q, parity_d;
`endif

    // Bit that sits at the output end of a shift-register image.
    function automatic logic head_bit(input logic [w-1:0] v);
        return lsb_first ? v[0] : v[w-1];
    endfunction

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        sr_shift  = lsb_first ? (sr_q >> 1) : (sr_q << 1);
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        s_out_d   = s_out_q;
        s_valid_d = s_valid_q;
        s_last_d  = s_last_q;
        done_d    = 1'b0;
`ifdef SHIFT_SER_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (d_valid) begin
                    state_d   = SHIFT;
                    sr_d      = d;
                    cnt_d     = '0;
                    s_valid_d = 1'b1;
                    s_out_d   = head_bit(d);
                    s_last_d  = 1'b0;   // w >= 2, so the first beat is never last
`ifdef SHIFT_SER_TX_PARITY_EN
                    parity_d  = ^d;
`endif
                end
            end

            SHIFT: begin
                if (s_ready) begin
                    sr_d = sr_shift;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
`ifdef SHIFT_SER_TX_PARITY_EN
                        state_d  = PAR;
                        s_out_d  = parity_q;
                        s_last_d = 1'b1;
`else
                        state_d   = IDLE;
                        s_valid_d = 1'b0;
                        s_out_d   = 1'b0;
                        s_last_d  = 1'b0;
                        done_d    = 1'b1;
`endif
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        s_out_d = head_bit(sr_shift);
`ifdef SHIFT_SER_TX_PARITY_EN
                        s_last_d = 1'b0;
`else
                        s_last_d = (cnt_q == CNT_PENULT);
`endif
                    end
                end
            end

`ifdef SHIFT_SER_TX_PARITY_EN
            PAR: begin
                if (s_ready) begin
                    state_d   = IDLE;
                    s_valid_d = 1'b0;
                    s_out_d   = 1'b0;
                    s_last_d  = 1'b0;
                    done_d    = 1'b1;
                end
            end
`endif

            default: begin
                // Unreachable encodings recover to a clean IDLE.
                state_d   = IDLE;
                sr_d      = '0;
                cnt_d     = '0;
                s_valid_d = 1'b0;
                s_out_d   = 1'b0;
                s_last_d  = 1'b0;
            end
        endcase
    end

    // Single state register: FSM state, datapath and the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            s_out_q   <= 1'b0;
            s_valid_q <= 1'b0;
            s_last_q  <= 1'b0;
            done_q    <= 1'b0;
`ifdef SHIFT_SER_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            s_out_q   <= s_out_d;
            s_valid_q <= s_valid_d;
            s_last_q  <= s_last_d;
            done_q    <= done_d;
`ifdef SHIFT_SER_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign d_ready = (state_q == IDLE);
    assign busy    = (state_q != IDLE);
    assign s_out   = s_out_q;
    assign s_valid = s_valid_q;
    assign s_last  = s_last_q;
    assign done    = done_q;

endmodule
